ysyx_25040129_ifu_prefetch: RTL and testbench

Parametrised instruction fetch unit with a prefetch queue. It replaces the blocking single-instruction fetch sequence, in which fetch waits for writeback before issuing. It keeps up to DEPTH fetched instructions buffered ahead of the IDU, fetching sequentially until a redirect arrives. It sits between the memory/bus port and the IDU; the WBU/EXU drives redirects.

---
 rtl/ysyx_25040129_ifu_prefetch_if.sv | 48 ++++
 rtl/ysyx_25040129_ifu_prefetch.sv | 172 +++++++++++++++++
 tb/tb_ysyx_25040129_ifu_prefetch.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25040129_ifu_prefetch_if.sv
// Bundle of redirect, memory-port and IDU-side signals for the prefetch IFU.
// master = IFU side, slave = memory/IDU/redirect side.
interface ysyx_25040129_ifu_prefetch_if #(
  parameter int XLEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_rsp_valid;
  logic            mem_rsp_ready;
  logic [XLEN-1:0] mem_rsp_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_inst;

  modport master (
    input  redirect_valid,
    input  redirect_pc,
    output mem_req_valid,
    input  mem_req_ready,
    output mem_req_addr,
    input  mem_rsp_valid,
    output mem_rsp_ready,
    input  mem_rsp_data,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_inst
  );

  modport slave (
    output redirect_valid,
    output redirect_pc,
    input  mem_req_valid,
    output mem_req_ready,
    input  mem_req_addr,
    output mem_rsp_valid,
    input  mem_rsp_ready,
    output mem_rsp_data,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_inst
  );
endinterface

// File: rtl/ysyx_25040129_ifu_prefetch.sv
// Prefetching IFU: one fetch in flight, DEPTH-entry queue toward the IDU.
// Optional perf counters: define YSYX_25040129_IFU_PF_PERF_EN.
module ysyx_25040129_ifu_prefetch #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic clk,
  input  logic rst,
`ifdef YSYX_25040129_IFU_PF_PERF_EN
  output logic [63:0] perf_fetch_cnt,
  output logic [31:0] perf_drop_cnt,
  output logic [31:0] perf_stall_cnt,
`endif
  ysyx_25040129_ifu_prefetch_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RSP  = 2'd2;

  logic [1:0]      state_q,    state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic            drop_q,     drop_d;
  logic [PW-1:0]   head_q,     head_d;
  logic [PW-1:0]   tail_q,     tail_d;
  logic [CW-1:0]   count_q,    count_d;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] inst_mem [DEPTH];

  logic redir;
  logic req_fire;
  logic rsp_fire;
  logic pop;
  logic push;

  // Handshake events for this cycle.
  always_comb begin
    redir    = bus.redirect_valid;
    req_fire = (state_q == S_REQ) && bus.mem_req_ready;
    rsp_fire = (state_q == S_RSP) && bus.mem_rsp_valid;
    pop      = (count_q != '0) && bus.out_ready;
    push     = rsp_fire && !drop_q && !redir;
  end

  // Queue pointers/count; a redirect flushes after any pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redir) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Sequential fetch PC and stale-response drop flag.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    if (redir) begin
      fetch_pc_d = bus.redirect_pc;
      drop_d     = (state_q != S_IDLE) && !rsp_fire;
    end else if (rsp_fire) begin
      drop_d = 1'b0;
      if (!drop_q) fetch_pc_d = fetch_pc_q + XLEN'(XLEN / 8);
    end
  end

  // Fetch FSM; issue only if the next-cycle count leaves a credit.
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    case (state_q)
      S_IDLE: begin
        if (count_d < CW'(DEPTH)) begin
          state_d    = S_REQ;
          req_addr_d = fetch_pc_d;
        end
      end
      S_REQ: begin
        if (req_fire) state_d = S_RSP;
      end
      S_RSP: begin
        if (rsp_fire) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      drop_q     <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Queue storage, written at the tail on push.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_q]   <= fetch_pc_q;
      inst_mem[tail_q] <= bus.mem_rsp_data;
    end
  end

  assign bus.mem_req_valid = (state_q == S_REQ);
  assign bus.mem_req_addr  = req_addr_q;
  assign bus.mem_rsp_ready = (state_q == S_RSP);
  assign bus.out_valid     = (count_q != '0);
  assign bus.out_pc        = pc_mem[head_q];
  assign bus.out_inst      = inst_mem[head_q];

`ifdef YSYX_25040129_IFU_PF_PERF_EN
  logic [63:0]   perf_fetch_q, perf_fetch_d;
  logic [31:0]   perf_drop_q,  perf_drop_d;
  logic [31:0]   perf_stall_q, perf_stall_d;
  logic          rsp_dropped;
  logic [CW-1:0] flushed;

  // Fetched, discarded and IDU-starved event counters.
  always_comb begin
    rsp_dropped  = rsp_fire && (drop_q || redir);
    flushed      = redir ? (count_q - CW'(pop)) : '0;
    perf_fetch_d = perf_fetch_q + 64'(push);
    perf_drop_d  = perf_drop_q + 32'(rsp_dropped) + 32'(flushed);
    perf_stall_d = perf_stall_q
                 + 32'((count_q == '0) && bus.out_ready);
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_drop_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_drop_q  <= perf_drop_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_drop_cnt  = perf_drop_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_ysyx_25040129_ifu_prefetch.sv
// Directed bench for the prefetch IFU.
// Memory returns ~addr as the instruction word.
module tb_ysyx_25040129_ifu_prefetch;

  logic clk;
  logic rst;

  ysyx_25040129_ifu_prefetch_if #(.XLEN(32)) bus ();

`ifdef YSYX_25040129_IFU_PF_PERF_EN
  logic [63:0] perf_fetch_cnt;
  logic [31:0] perf_drop_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  ysyx_25040129_ifu_prefetch #(
    .XLEN(32),
    .DEPTH(4),
    .RESET_PC(32'h8000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef YSYX_25040129_IFU_PF_PERF_EN
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_drop_cnt(perf_drop_cnt),
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  int          lat;
  bit          rdy_en;
  bit          pend;
  int          wcnt;
  logic [31:0] paddr;
  bit          req_fire_q;
  bit          rsp_fire_q;
  logic [31:0] req_addr_tb;
  logic [31:0] last_acc;
  int          n_req;
  int          n_rsp;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic mem_cycle();
    if (rsp_fire_q) begin
      pend = 1'b0;
      n_rsp++;
    end
    if (req_fire_q) begin
      pend     = 1'b1;
      paddr    = req_addr_tb;
      wcnt     = lat - 1;
      n_req++;
      last_acc = req_addr_tb;
    end else if (pend && wcnt > 0) begin
      wcnt--;
    end
    bus.mem_req_ready = rdy_en;
    bus.mem_rsp_valid = pend && (wcnt == 0);
    bus.mem_rsp_data  = ~paddr;
    req_fire_q  = bus.mem_req_valid && bus.mem_req_ready;
    req_addr_tb = bus.mem_req_addr;
    rsp_fire_q  = bus.mem_rsp_valid && bus.mem_rsp_ready;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
    mem_cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    pend = 1'b0;
    wcnt = 0;
    req_fire_q = 1'b0;
    rsp_fire_q = 1'b0;
    n_req = 0;
    n_rsp = 0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic redirect(logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
  endtask

  task automatic expect_out(string tag, logic [31:0] pc);
    int n = 0;
    while (!bus.out_valid && n < 20) begin
      cyc();
      n++;
    end
    chk({tag, "_v"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_pc"}, bus.out_pc, pc);
    chk({tag, "_inst"}, bus.out_inst, ~pc);
    cyc();
  endtask

  task automatic wait_req(string tag, logic [31:0] addr, int lim);
    int n = 0;
    while (!bus.mem_req_valid && n < lim) begin
      cyc();
      n++;
    end
    chk({tag, "_v"}, 32'(bus.mem_req_valid), 32'd1);
    chk({tag, "_a"}, bus.mem_req_addr, addr);
  endtask

  task automatic wait_acc(string tag, int k, logic [31:0] addr);
    int n = 0;
    while (n_req < k && n < 30) begin
      cyc();
      n++;
    end
    chk({tag, "_n"}, 32'(n_req), 32'(k));
    chk({tag, "_a"}, last_acc, addr);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    lat = 1;
    rdy_en = 1'b1;
    paddr = '0;
    req_addr_tb = '0;
    last_acc = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;

    // reset state and sequential fetch
    cyc();
    chk("rst_reqv", 32'(bus.mem_req_valid), 32'd0);
    chk("rst_rspr", 32'(bus.mem_rsp_ready), 32'd0);
    chk("rst_outv", 32'(bus.out_valid), 32'd0);
    do_reset();
    chk("rel_reqv", 32'(bus.mem_req_valid), 32'd0);
    cyc();
    chk("first_reqv", 32'(bus.mem_req_valid), 32'd1);
    chk("first_addr", bus.mem_req_addr, 32'h8000_0000);
    expect_out("seq0", 32'h8000_0000);
    expect_out("seq1", 32'h8000_0004);
    expect_out("seq2", 32'h8000_0008);

    // fill with IDU stalled, then resume
    bus.out_ready = 1'b0;
    do_reset();
    repeat (30) cyc();
    chk("fill_n", 32'(n_rsp), 32'd4);
    chk("fill_reqv", 32'(bus.mem_req_valid), 32'd0);
    chk("fill_outv", 32'(bus.out_valid), 32'd1);
    repeat (10) cyc();
    chk("fill_nreq", 32'(n_req), 32'd4);
    bus.out_ready = 1'b1;
    expect_out("fill0", 32'h8000_0000);
    bus.out_ready = 1'b0;
    wait_req("resume", 32'h8000_0010, 3);
    bus.out_ready = 1'b1;
    expect_out("fill1", 32'h8000_0004);
    expect_out("fill2", 32'h8000_0008);
    expect_out("fill3", 32'h8000_000C);
    expect_out("fill4", 32'h8000_0010);

    // redirect while waiting in S_RSP, 3-cycle memory
    lat = 3;
    do_reset();
    wait_req("r1_req", 32'h8000_0000, 5);
    cyc();
    chk("r1_rspr", 32'(bus.mem_rsp_ready), 32'd1);
    redirect(32'h8000_0100);
    cyc();
    wait_acc("r1_acc", 2, 32'h8000_0100);
    expect_out("r1_out", 32'h8000_0100);

    // redirect with response and pop in the same cycle
    lat = 1;
    bus.out_ready = 1'b0;
    do_reset();
    begin
      int n = 0;
      while (!(n_rsp == 3 && bus.mem_rsp_valid && bus.mem_rsp_ready)
             && n < 40) begin
        cyc();
        n++;
      end
    end
    chk("r2_rsp", 32'(bus.mem_rsp_ready && bus.mem_rsp_valid), 32'd1);
    chk("r2_head", bus.out_pc, 32'h8000_0000);
    redirect(32'h8000_0200);
    bus.out_ready = 1'b1;
    cyc();
    chk("r2_outv", 32'(bus.out_valid), 32'd0);
    wait_req("r2_req", 32'h8000_0200, 4);
    expect_out("r2_out", 32'h8000_0200);

    // request held off by the memory, redirect mid-wait
    rdy_en = 1'b0;
    do_reset();
    cyc();
    chk("r3_reqv", 32'(bus.mem_req_valid), 32'd1);
    cyc();
    redirect(32'h8000_0300);
    cyc();
    chk("r3_hold1", bus.mem_req_addr, 32'h8000_0000);
    chk("r3_holdv", 32'(bus.mem_req_valid), 32'd1);
    cyc();
    cyc();
    chk("r3_hold2", bus.mem_req_addr, 32'h8000_0000);
    rdy_en = 1'b1;
    cyc();
    wait_acc("r3_acc1", 1, 32'h8000_0000);
    wait_acc("r3_acc2", 2, 32'h8000_0300);
    expect_out("r3_out", 32'h8000_0300);

    // address wrap at the top of the space
    do_reset();
    redirect(32'hFFFF_FFFC);
    cyc();
    chk("wrap_reqv", 32'(bus.mem_req_valid), 32'd1);
    chk("wrap_addr", bus.mem_req_addr, 32'hFFFF_FFFC);
    expect_out("wrap0", 32'hFFFF_FFFC);
    expect_out("wrap1", 32'h0000_0000);

    // reset in S_RSP, late stale response ignored
    lat = 3;
    do_reset();
    wait_req("rr_req", 32'h8000_0000, 5);
    cyc();
    chk("rr_rspr", 32'(bus.mem_rsp_ready), 32'd1);
    rst = 1'b1;
    paddr = 32'hDEAD_BEE0;
    cyc();
    chk("rr_rspr0", 32'(bus.mem_rsp_ready), 32'd0);
    cyc();
    cyc();
    chk("rr_rspr1", 32'(bus.mem_rsp_ready), 32'd0);
    chk("rr_reqv", 32'(bus.mem_req_valid), 32'd0);
    chk("rr_outv", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    cyc();
    chk("rr_rspr2", 32'(bus.mem_rsp_ready), 32'd0);
    expect_out("rr_out", 32'h8000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
